// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped timer peripheral: register word
// offsets (Address[4:2]), TCON bit positions and the default window base.
package mmio_pkg;

  // Default base of the 32-byte peripheral window (32-byte aligned).
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Word offsets within the window, i.e. byte offset >> 2.
  localparam logic [2:0] OFF_TH       = 3'd0; // 0x00
  localparam logic [2:0] OFF_TL       = 3'd1; // 0x04
  localparam logic [2:0] OFF_TCON     = 3'd2; // 0x08
  localparam logic [2:0] OFF_LED      = 3'd3; // 0x0C
  localparam logic [2:0] OFF_DIGI     = 3'd4; // 0x10
  localparam logic [2:0] OFF_SYSTICK  = 3'd5; // 0x14
  localparam logic [2:0] OFF_PRESCALE = 3'd6; // 0x18

  // TCON bit indices.
  localparam int TCON_EN    = 0;
  localparam int TCON_IRQEN = 1;
  localparam int TCON_IRQST = 2;

endpackage

// File: rtl/mmio_timer_peripheral_timer_core.sv
// Reloadable interval timer: TH (reload), TL (counter), TCON (enable,
// irq enable, sticky irq status). Optional prescaler when the macro
// TIMER_PRESCALER_EN is defined; otherwise the timer ticks every enabled
// cycle and the prescale output is tied to zero.
module timer_core
  import mmio_pkg::*;
#(
  parameter int PRESCALE_W = 16 // must not exceed 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_th,
  input  logic                  wr_tl,
  input  logic                  wr_tcon,
`ifdef TIMER_PRESCALER_EN
  input  logic                  wr_pre,
`endif
  input  logic [31:0]           wdata,
  output logic [31:0]           th,
  output logic [31:0]           tl,
  output logic [2:0]            tcon,
  output logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic                  irq
);

  logic overflow;
  logic ovf_irq;

`ifdef TIMER_PRESCALER_EN
  localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  pre_hit;

  assign pre_hit = (pre_cnt == prescale);
  assign tick    = tcon[TCON_EN] && pre_hit;

  // Prescale register and divider; the divider restarts whenever the timer
  // is disabled or the divide ratio is rewritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr_pre) prescale <= wdata[PRESCALE_W-1:0];
      if (!tcon[TCON_EN] || wr_pre) pre_cnt <= '0;
      else if (pre_hit)             pre_cnt <= '0;
      else                          pre_cnt <= pre_cnt + PRE_ONE;
    end
  end
`else
  assign tick     = tcon[TCON_EN];
  assign prescale = '0;
`endif

  assign overflow = tick && (tl == 32'hFFFF_FFFF);
  assign ovf_irq  = overflow && tcon[TCON_IRQEN];
  assign irq      = tcon[TCON_IRQST];

  // TH is written only by the CPU; a write in an overflow cycle only affects
  // the next reload because TL samples the old TH at this same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     th <= '0;
    else if (wr_th) th <= wdata;
  end

  // Counter: a CPU write beats the tick; overflow reloads from TH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        tl <= '0;
    else if (wr_tl)    tl <= wdata;
    else if (overflow) tl <= th;
    else if (tick)     tl <= tl + 32'd1;
  end

  // Control/status: irq_status is sticky and an overflow in the same cycle
  // as a TCON write is OR-ed in so it is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= '0;
    end else if (wr_tcon) begin
      tcon[TCON_EN]    <= wdata[TCON_EN];
      tcon[TCON_IRQEN] <= wdata[TCON_IRQEN];
      tcon[TCON_IRQST] <= wdata[TCON_IRQST] | ovf_irq;
    end else if (ovf_irq) begin
      tcon[TCON_IRQST] <= 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer_peripheral.sv
// Memory-mapped peripheral on the CPU data port: address decode, LED/DIGI
// registers, free-running SYSTICK, combinational read mux, and the interval
// timer (timer_core). Optional prescaler enabled by TIMER_PRESCALER_EN.
//
// Bus strobes: a load is MemRead && hit, answered combinationally in the
// same cycle with no wait states; a store is MemWrite && hit and commits at
// the next rising clk edge. There is no back-pressure. With both strobes
// high the read returns the value from before the store commits.
module mmio_timer_peripheral
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digi
);

  logic [2:0]            offset;
  logic                  we;
  logic [31:0]           th;
  logic [31:0]           tl;
  logic [2:0]            tcon;
  logic [PRESCALE_W-1:0] prescale;
  logic                  tick;
  logic [31:0]           systick;
  logic                  unused_bits;

  // Byte lanes are not supported; the low address bits are ignored.
  assign unused_bits = &{1'b0, Address[1:0], tick};

  assign hit    = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset = Address[4:2];
  assign we     = hit && MemWrite;

  timer_core #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .wr_th    (we && (offset == OFF_TH)),
    .wr_tl    (we && (offset == OFF_TL)),
    .wr_tcon  (we && (offset == OFF_TCON)),
`ifdef TIMER_PRESCALER_EN
    .wr_pre   (we && (offset == OFF_PRESCALE)),
`endif
    .wdata    (Write_data),
    .th       (th),
    .tl       (tl),
    .tcon     (tcon),
    .prescale (prescale),
    .tick     (tick),
    .irq      (irq)
  );

  // LED and seven-segment registers keep only their low bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds <= '0;
      digi <= '0;
    end else if (we) begin
      if (offset == OFF_LED)  leds <= Write_data[7:0];
      if (offset == OFF_DIGI) digi <= Write_data[11:0];
    end
  end

  // Free-running cycle counter, read-only, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick <= '0;
    else        systick <= systick + 32'd1;
  end

  // Zero-latency read mux; returns 0 unless this block is being read.
  always_comb begin
    Read_data = '0;
    if (hit && MemRead) begin
      case (offset)
        OFF_TH:       Read_data = th;
        OFF_TL:       Read_data = tl;
        OFF_TCON:     Read_data = {29'd0, tcon};
        OFF_LED:      Read_data = {24'd0, leds};
        OFF_DIGI:     Read_data = {20'd0, digi};
        OFF_SYSTICK:  Read_data = systick;
        OFF_PRESCALE: Read_data = 32'(prescale);
        default:      Read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_peripheral.sv
// Directed bench for mmio_timer_peripheral: a register-access vector table
// followed by hand-written timer, irq, SYSTICK and reset sequences.
module tb_mmio_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH = BASE + 32'h00;
  localparam logic [31:0] A_TL = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED = BASE + 32'h0C;
  localparam logic [31:0] A_DIGI = BASE + 32'h10;
  localparam logic [31:0] A_SYS = BASE + 32'h14;
  localparam logic [31:0] A_PRE = BASE + 32'h18;
  localparam logic [31:0] A_1C = BASE + 32'h1C;
`ifdef TIMER_PRESCALER_EN
  localparam logic [31:0] PRE_EXP = 32'd3;
`else
  localparam logic [31:0] PRE_EXP = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        hit;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digi;

  int checks;
  int errors;

  mmio_timer_peripheral dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .hit        (hit),
    .irq        (irq),
    .leds       (leds),
    .digi       (digi)
  );

  // Clock and reference cycle count since reset release.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sys_model;
  always @(posedge clk or negedge reset) begin
    if (!reset) sys_model <= '0;
    else        sys_model <= sys_model + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks; each starts and ends at a falling edge, except reads,
  // which sample #1 later without crossing a clock edge.
  task automatic op_write(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic op_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1;
    #1;
    check(name, Read_data, exp);
    MemRead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[19];
  logic [31:0] s0;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;

    // Register-access vectors (applied after reset release).
    tbl[0]  = '{"wr_led",     0, 1, A_LED,  32'h0000_01A5, 32'h0,          1};
    tbl[1]  = '{"rd_led",     1, 0, A_LED,  32'h0,         32'h0000_00A5,  1};
    tbl[2]  = '{"wr_digi",    0, 1, A_DIGI, 32'h0000_FFFF, 32'h0,          1};
    tbl[3]  = '{"rd_digi",    1, 0, A_DIGI, 32'h0,         32'h0000_0FFF,  1};
    tbl[4]  = '{"wr_th",      0, 1, A_TH,   32'h1234_5678, 32'h0,          1};
    tbl[5]  = '{"rd_th",      1, 0, A_TH,   32'h0,         32'h1234_5678,  1};
    tbl[6]  = '{"wr_tcon_hi", 0, 1, A_TCON, 32'hFFFF_FFF8, 32'h0,          1};
    tbl[7]  = '{"rd_tcon_hi", 1, 0, A_TCON, 32'h0,         32'h0,          1};
    tbl[8]  = '{"wr_1c",      0, 1, A_1C,   32'hDEAD_BEEF, 32'h0,          1};
    tbl[9]  = '{"rd_1c",      1, 0, A_1C,   32'h0,         32'h0,          1};
    tbl[10] = '{"wr_pre",     0, 1, A_PRE,  32'h0000_0003, 32'h0,          1};
    tbl[11] = '{"rd_pre",     1, 0, A_PRE,  32'h0,         PRE_EXP,        1};
    tbl[12] = '{"wr_pre0",    0, 1, A_PRE,  32'h0,         32'h0,          1};
    tbl[13] = '{"rd_led_b3",  1, 0, BASE + 32'h0F, 32'h0,  32'h0000_00A5,  1};
    tbl[14] = '{"wr_miss",    0, 1, 32'h0000_000C, 32'h0,  32'h0,          0};
    tbl[15] = '{"rd_led_kept",1, 0, A_LED,  32'h0,         32'h0000_00A5,  1};
    tbl[16] = '{"rd_above",   1, 0, BASE + 32'h20, 32'h0,  32'h0,          0};
    tbl[17] = '{"rd_below",   1, 0, 32'h3FFF_FFFC, 32'h0,  32'h0,          0};
    tbl[18] = '{"no_strobe",  0, 0, A_LED,  32'h0,         32'h0,          1};

    // Reset state: everything reads zero while reset is held.
    idle(3);
    for (int i = 0; i < 8; i++)
      op_read($sformatf("rst_rd_%0d", i), BASE + 32'(i * 4), 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_leds", {24'd0, leds}, 32'h0);
    check("rst_digi", {20'd0, digi}, 32'h0);
    op_read("miss_rd", 32'h1000_0000, 32'h0);
    Address = 32'h1000_0000; #1;
    check("miss_hit", {31'd0, hit}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table.
    for (int i = 0; i < 19; i++) begin
      Address = tbl[i].addr; Write_data = tbl[i].wdata;
      MemRead = tbl[i].rd;   MemWrite = tbl[i].wr;
      #1;
      check({tbl[i].name, "_data"}, Read_data, tbl[i].exp_rd);
      check({tbl[i].name, "_hit"}, {31'd0, hit}, {31'd0, tbl[i].exp_hit});
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
    end
    check("leds_out", {24'd0, leds}, 32'h0000_00A5);
    check("digi_out", {20'd0, digi}, 32'h0000_0FFF);

    // Read and write of the same register in one cycle.
    Address = A_LED; Write_data = 32'h3C; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    check("rw_old", Read_data, 32'h0000_00A5);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    check("rw_new", {24'd0, leds}, 32'h0000_003C);

    // SYSTICK: absolute value, 10-cycle delta, write ignored.
    op_read("sys_abs", A_SYS, sys_model);
    Address = A_SYS; MemRead = 1'b1; #1; s0 = Read_data; MemRead = 1'b0;
    idle(10);
    op_read("sys_delta", A_SYS, s0 + 32'd10);
    op_write(A_SYS, 32'h0000_0000);
    op_read("sys_wr_ign", A_SYS, sys_model);

    // Reload and interrupt.
    op_write(A_TH, 32'hFFFF_FFFC);
    op_write(A_TL, 32'hFFFF_FFFE);
    op_write(A_TCON, 32'h3);
    op_read("tl_start", A_TL, 32'hFFFF_FFFE);
    idle(1);
    op_read("tl_max", A_TL, 32'hFFFF_FFFF);
    check("irq_before", {31'd0, irq}, 32'h0);
    idle(1);
    op_read("tl_reload", A_TL, 32'hFFFF_FFFC);
    check("irq_set", {31'd0, irq}, 32'h1);
    op_read("tcon_7", A_TCON, 32'h7);

    // Sticky clear in a quiet cycle, then a clear colliding with overflow.
    op_write(A_TCON, 32'h3);
    check("irq_clr", {31'd0, irq}, 32'h0);
    op_read("tcon_3", A_TCON, 32'h3);
    idle(2);
    op_read("tl_pre_ovf", A_TL, 32'hFFFF_FFFF);
    op_write(A_TCON, 32'h3);
    check("irq_kept", {31'd0, irq}, 32'h1);
    op_read("tcon_coll", A_TCON, 32'h7);
    op_read("tl_coll", A_TL, 32'hFFFF_FFFC);

    // TH write during overflow: reload uses the old TH.
    idle(3);
    op_write(A_TH, 32'h10);
    op_read("tl_old_th", A_TL, 32'hFFFF_FFFC);
    op_read("th_new", A_TH, 32'h10);
    idle(4);
    op_read("tl_new_th", A_TL, 32'h10);

    // TL write beats the tick.
    op_write(A_TL, 32'd5);
    op_write(A_TL, 32'd100);
    op_read("tl_wr_win", A_TL, 32'd100);
    idle(1);
    op_read("tl_after", A_TL, 32'd101);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b0;
    #1;
    op_read("async_tl", A_TL, 32'h0);
    check("async_irq", {31'd0, irq}, 32'h0);
    check("async_leds", {24'd0, leds}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

`ifdef TIMER_PRESCALER_EN
    op_write(A_PRE, 32'd3);
    op_write(A_TL, 32'd0);
    op_write(A_TCON, 32'h1);
    op_read("pre_t0", A_TL, 32'd0);
    idle(3);
    op_read("pre_t3", A_TL, 32'd0);
    idle(1);
    op_read("pre_t4", A_TL, 32'd1);
    idle(4);
    op_read("pre_t8", A_TL, 32'd2);
`else
    op_write(A_TL, 32'd0);
    op_write(A_TCON, 32'h1);
    op_read("tick_t0", A_TL, 32'd0);
    idle(1);
    op_read("tick_t1", A_TL, 32'd1);
    idle(3);
    op_read("tick_t4", A_TL, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
